// File: rtl/inst_decode_queue.sv
// rtl/inst_decode_queue.sv - instruction decoder feeding a DEPTH-entry decoded-instruction FIFO
// Control word layout (MSB..LSB): v, pc[31:0], type[2:0], opcode, rd, funct3, rs1, rs2, funct7, 8 flags.
module inst_decode_queue #(
    parameter int DEPTH     = 4,
    parameter bit BRANCH_EN = 1'b1
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         flush_i,
    input  logic [31:0]                  pc_i,
    input  logic                         ir_v_i,
    input  logic [31:0]                  ir_i,
    output logic                         ir_ready_o,
    output logic                         decoded_v_o,
    output logic [75:0]                  decoded_o,
    output logic [31:0]                  imm_o,
    output logic                         illegal_o,
    input  logic                         decoded_yumi_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3,
                           T_U = 3'd4, T_J = 3'd5, T_E = 3'd6;

    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;

    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3, itype;
    logic        imm_v, addpc_v, rd_w_v, jmp_v, br_v, shift_v, dmem_r_v, dmem_w_v;
    logic        dec_illegal, is_shift_f3;
    logic [31:0] dec_imm;
    logic [75:0] dec_cword;

    always_comb begin
        opcode      = ir_i[6:0];
        rd          = ir_i[11:7];
        funct3      = ir_i[14:12];
        rs1         = ir_i[19:15];
        rs2         = ir_i[24:20];
        funct7      = ir_i[31:25];
        itype       = T_E;
        imm_v       = 1'b0;
        addpc_v     = 1'b0;
        rd_w_v      = 1'b0;
        jmp_v       = 1'b0;
        br_v        = 1'b0;
        shift_v     = 1'b0;
        dmem_r_v    = 1'b0;
        dmem_w_v    = 1'b0;
        dec_illegal = 1'b0;
        is_shift_f3 = (ir_i[14:12] == 3'b001) || (ir_i[14:12] == 3'b101);
        case (opcode)
            OP_AUIPC: begin itype = T_U; imm_v = 1'b1; addpc_v = 1'b1; rd_w_v = 1'b1; end
            OP_LUI: begin
                itype = T_U; funct3 = 3'b000; funct7 = 7'd0; rs1 = 5'd0;
                imm_v = 1'b1; rd_w_v = 1'b1;
            end
            OP_JAL: begin itype = T_J; addpc_v = 1'b1; imm_v = 1'b1; jmp_v = 1'b1; rd_w_v = 1'b1; end
            OP_JALR: begin
                itype = T_I; funct3 = 3'b000; funct7 = 7'd0;
                imm_v = 1'b1; jmp_v = 1'b1; rd_w_v = 1'b1;
            end
            OP_IMM: begin
                itype = T_I; imm_v = 1'b1; rd_w_v = 1'b1;
                // Shift-immediates keep funct7 to tell SRLI from SRAI.
                if (is_shift_f3) shift_v = 1'b1;
                else             funct7  = 7'd0;
            end
            OP_REG:   begin itype = T_R; rd_w_v = 1'b1; shift_v = is_shift_f3; end
            OP_LOAD:  begin itype = T_I; imm_v = 1'b1; dmem_r_v = 1'b1; rd_w_v = 1'b1; end
            OP_STORE: begin itype = T_S; imm_v = 1'b1; dmem_w_v = 1'b1; end
            OP_BRANCH: begin
                if (BRANCH_EN) begin itype = T_B; br_v = 1'b1; imm_v = 1'b1; end
                else           dec_illegal = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        dec_imm = 32'd0;
        case (itype)
            T_I: dec_imm = {{20{ir_i[31]}}, ir_i[31:20]};
            T_S: dec_imm = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
            T_B: dec_imm = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
            T_U: dec_imm = {ir_i[31:12], 12'd0};
            T_J: dec_imm = {{11{ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};
            default: dec_imm = 32'd0;
        endcase
    end

    assign dec_cword = {1'b1, pc_i, itype, opcode, rd, funct3, rs1, rs2, funct7,
                        imm_v, addpc_v, rd_w_v, jmp_v, br_v, shift_v, dmem_r_v, dmem_w_v};

    logic [CW-1:0] count_q;
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [75:0]   cw_mem  [DEPTH];
    logic [31:0]   imm_mem [DEPTH];
    logic          ill_mem [DEPTH];
    logic          enq, deq;

    assign ir_ready_o  = (count_q < FULL_CNT);
    assign decoded_v_o = (count_q != '0);
    assign enq         = ir_v_i && ir_ready_o && !flush_i;
    assign deq         = decoded_v_o && decoded_yumi_i;

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            if (enq) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (deq) rd_ptr_q <= rd_ptr_q + PW'(1);
            if (enq && !deq)      count_q <= count_q + CW'(1);
            else if (!enq && deq) count_q <= count_q - CW'(1);
        end
    end

    // Payload storage is deliberately unreset; only occupancy tracking is.
    always_ff @(posedge clk_i) begin
        if (enq && !reset_i) begin
            cw_mem[wr_ptr_q]  <= dec_cword;
            imm_mem[wr_ptr_q] <= dec_imm;
            ill_mem[wr_ptr_q] <= dec_illegal;
        end
    end

    assign decoded_o = cw_mem[rd_ptr_q];
    assign imm_o     = imm_mem[rd_ptr_q];
    assign illegal_o = ill_mem[rd_ptr_q];
    assign count_o   = count_q;
endmodule

// File: doc/inst_decode_queue.md
INST_DECODE_QUEUE -- requirements
Module: inst_decode_queue

Interface
REQ-001 Parameter DEPTH, default 4, is the number of decoded-entry slots; it SHALL be a power of two and at least 2.
REQ-002 Parameter BRANCH_EN, default 1: 1 means branch opcode decodes as legal; 0 means it decodes as illegal.
REQ-003 Port clk_i, input, 1 bit, is the sole clock; all state SHALL update on its rising edge.
REQ-004 Port reset_i, input, 1 bit, is the reset; it SHALL be synchronous and active-high.
REQ-005 Port flush_i, input, 1 bit, requests discard of all queued entries.
REQ-006 Port pc_i, input, rvga_word, is the PC of the offered instruction.
REQ-007 Port ir_v_i, input, 1 bit, marks the offered instruction valid.
REQ-008 Port ir_i, input, rvga_word, is the offered instruction word.
REQ-009 Port ir_ready_o, output, 1 bit, means the queue can accept an instruction this cycle.
REQ-010 Port decoded_v_o, output, 1 bit, means the head entry is valid.
REQ-011 Port decoded_o, output, rvga_cword, is the head entry's decoded control word.
REQ-012 Port imm_o, output, rvga_word, is the head entry's sign-extended immediate.
REQ-013 Port illegal_o, output, 1 bit, marks the head entry as having an unsupported opcode.
REQ-014 Port decoded_yumi_i, input, 1 bit, means the consumer takes the head entry this cycle.
REQ-015 Port count_o, output, $clog2(DEPTH+1) bits, is the current occupancy.

Function
REQ-016 Decode SHALL be combinational on ir_i at enqueue; each stored entry SHALL hold the control word, the immediate and the illegal flag.
- Field extraction: opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20], funct7 [31:25].
- pc is carried through unchanged.
- v SHALL be 1 in every stored entry.
REQ-017 Per-opcode flags SHALL be as follows; flags not listed are 0.
- auipc: type u; imm_v, addpc_v, rd_w_v.
- lui: type u; funct3=addsub, funct7=0, rs1=0; imm_v, rd_w_v.
- jal: type j; addpc_v, imm_v, jmp_v, rd_w_v.
- jalr: type i; funct3=addsub, funct7=0; imm_v, jmp_v, rd_w_v.
- op-imm: type i; imm_v, rd_w_v; shift_v if funct3 is sll or srx, otherwise funct7 forced to 0.
- op-reg: type r; rd_w_v; shift_v if funct3 is sll or srx.
- load: type i; imm_v, dmem_r_v, rd_w_v.
- store: type s; imm_v, dmem_w_v.
REQ-018 Branch opcode (1100011) with BRANCH_EN=1 SHALL decode as type b with br_v=1, imm_v=1 and rd_w_v=0.
REQ-019 Any other opcode, and branch with BRANCH_EN=0, SHALL decode as type e with illegal=1 and all flags 0.
REQ-020 Immediate generation SHALL be:
- I: sext(ir[31:20]).
- S: sext({ir[31:25], ir[11:7]}).
- B: sext({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}).
- U: {ir[31:12], 12'b0}.
- J: sext({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}).
- R and e: 0.
REQ-021 Handshake:
- ir_ready_o = (count < DEPTH), with no combinational dependence on decoded_yumi_i.
- Enqueue occurs when ir_v_i && ir_ready_o && !flush_i.
REQ-022 Dequeue occurs when decoded_v_o && decoded_yumi_i; decoded_yumi_i while decoded_v_o=0 SHALL be ignored.
REQ-023 decoded_v_o = (count != 0); head outputs SHALL be driven from storage with no combinational path from ir_i.
REQ-024 Latency: an instruction accepted in cycle N SHALL appear at the head no earlier than cycle N+1, in FIFO order.
REQ-025 Simultaneous enqueue and dequeue SHALL leave count unchanged; both pointers advance.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; full and empty are distinguished by count.
REQ-027 When full, ir_ready_o=0; an offered instruction SHALL NOT be stored and SHALL NOT corrupt any entry.
REQ-028 flush_i=1 SHALL set count and both pointers to 0 at the next edge, discarding any same-cycle enqueue; a same-cycle dequeue SHALL have no further effect.
REQ-029 Head output fields SHALL be don't-care while decoded_v_o=0.

Reset
REQ-030 While reset_i=1 at a rising edge, count, read pointer and write pointer SHALL become 0; the reset takes priority over flush, enqueue and dequeue.
- After that edge: decoded_v_o=0, ir_ready_o=1, count_o=0.
- Storage contents are not reset.
REQ-031 Reset asserted mid-stream SHALL discard all entries; the first enqueue after deassertion SHALL be the next head.

Verification
REQ-032 Enqueue 0x00500093 (addi x1,x0,5) at pc 0x100 -> next cycle: v=1, type i, rd=1, rs1=0, imm_o=0x00000005, rd_w_v=1, illegal_o=0.
REQ-033 Enqueue 0xFE208CE3 (beq x1,x2,-8) with BRANCH_EN=1 -> type b, br_v=1, imm_o=0xFFFFFFF8; with BRANCH_EN=0 -> illegal_o=1, type e.
REQ-034 Enqueue 0x123452B7 (lui x5) -> imm_o=0x12345000, rs1=0, funct7=0; then 0xFFFFFFFF -> illegal_o=1, all flags 0.
REQ-035 DEPTH=4: enqueue 5 with yumi=0 -> ir_ready_o=0 after 4, count_o=4, 5th not stored; yumi 4 times -> original order; count_o returns to 0.
REQ-036 With count=2: simultaneous enqueue+dequeue for 10 cycles -> count_o stays 2, order preserved across pointer wrap.
REQ-037 count=3, flush_i with same-cycle ir_v_i -> next cycle count_o=0, decoded_v_o=0; reset_i with count=2 -> count_o=0, ir_ready_o=1.
